// File: rtl/pe_feeder.sv
// Sequences one PE job: arm, load k_len taps, stream n_len MAC beats with tap replay, drain, done.
// All PE-side outputs registered (beat at edge t shows on pe_* in t+1); ready depends on state only, stalls become HOLD cycles.
module pe_feeder #(
  parameter int DW    = 8,
  parameter int KMAX  = 4,
  parameter int DRAIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(KMAX):0]  k_len,
  input  logic [7:0]             n_len,
  input  logic                   flt_valid,
  input  logic [DW-1:0]          flt_data,
  output logic                   flt_ready,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic [DW-1:0]          pe_in,
  output logic [DW-1:0]          pe_filter,
  output logic [1:0]             pe_mode,
  output logic                   pe_activate,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW  = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int KW  = $clog2(KMAX) + 1;
  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [1:0] MODE_HOLD   = 2'd3;
  localparam logic [1:0] MODE_FILTER = 2'd2;
  localparam logic [1:0] MODE_MAC    = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k_lat, kidx, tap;
  logic [7:0]      n_lat, ncnt;
  logic [DCW-1:0]  dcnt;
  logic [DW-1:0]   fbuf [KMAX];

  logic start_ok, flt_acc, in_acc;

  assign flt_ready = (state == S_LOAD);
  assign in_ready  = (state == S_MAC);
  assign flt_acc   = flt_valid & flt_ready;
  assign in_acc    = in_valid & in_ready;
  assign start_ok  = (k_len != '0) && (k_len <= KW'(KMAX)) && (n_len != 8'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && start_ok) state_nxt = S_ARM;
      S_ARM:   state_nxt = S_LOAD;
      S_LOAD:  if (flt_acc && (kidx == k_lat - KW'(1))) state_nxt = S_MAC;
      S_MAC:   if (in_acc && (ncnt == n_lat - 8'd1)) state_nxt = S_DRAIN;
      S_DRAIN: if (dcnt == DCW'(DRAIN - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      k_lat       <= '0;
      n_lat       <= '0;
      kidx        <= '0;
      tap         <= '0;
      ncnt        <= '0;
      dcnt        <= '0;
      pe_in       <= '0;
      pe_filter   <= '0;
      pe_mode     <= MODE_HOLD;
      pe_activate <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state == S_DONE);
      err     <= (state == S_IDLE) && start && !start_ok;
      pe_mode <= MODE_HOLD;
      case (state)
        S_IDLE: begin
          kidx <= '0;
          tap  <= '0;
          ncnt <= '0;
          dcnt <= '0;
          if (start && start_ok) begin
            k_lat <= k_len;
            n_lat <= n_len;
          end
        end
        S_ARM: pe_activate <= 1'b1;
        S_LOAD: begin
          if (flt_acc) begin
            pe_filter <= flt_data;
            pe_mode   <= MODE_FILTER;
            kidx      <= kidx + KW'(1);
          end
        end
        S_MAC: begin
          if (in_acc) begin
            pe_in     <= in_data;
            pe_filter <= fbuf[tap[AW-1:0]];
            pe_mode   <= MODE_MAC;
            ncnt      <= ncnt + 8'd1;
            // Replay wraps on the job's tap count, not the buffer depth.
            tap       <= (tap == k_lat - KW'(1)) ? '0 : tap + KW'(1);
          end
        end
        S_DRAIN: dcnt <= dcnt + DCW'(1);
        S_DONE:  pe_activate <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tap storage carries no reset; every slot used is written in LOAD first.
  always_ff @(posedge clk) begin
    if (flt_acc) fbuf[kidx[AW-1:0]] <= flt_data;
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: table of jobs and rejected starts, scoreboard of expected PE beats,
// plus hand sequences for mid-job reset and start held through a job.
module tb_pe_feeder;

  localparam int DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] k_len = '0;
  logic [7:0] n_len = '0;
  logic       flt_valid = 1'b0, in_valid = 1'b0;
  logic [7:0] flt_data = '0, in_data = '0;
  logic       flt_ready, in_ready;
  logic [7:0] pe_in, pe_filter;
  logic [1:0] pe_mode;
  logic       pe_activate, busy, done, err;

  pe_feeder #(.DW(8), .KMAX(4), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .n_len(n_len),
    .flt_valid(flt_valid), .flt_data(flt_data), .flt_ready(flt_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pe_in(pe_in), .pe_filter(pe_filter), .pe_mode(pe_mode),
    .pe_activate(pe_activate), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] pin;
    logic [7:0] pflt;
  } exp_t;

  // Job vector: stimulus plus the hand-derived cycle (after the start edge) at which done shows.
  typedef struct packed {
    int          k;
    int          n;
    int          fstall;   // bit i set: flt_valid low on the i-th LOAD cycle
    int          mstall;   // bit i set: in_valid low on the i-th MAC cycle
    logic [31:0] f;
    logic [63:0] d;
    int          exp_done;
  } job_t;

  typedef struct packed {
    int   k;
    int   n;
    logic exp_err;
  } rej_t;

  exp_t       q[$];
  logic [7:0] m_in = '0, m_filt = '0;
  logic [7:0] mbuf [8];
  int         n_vec = 0, n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    mk = '{mode: m, pin: a, pflt: b};
  endfunction

  task automatic abort_now(input logic [7:0] beat);
    bit saw_done;
    in_valid = 1'b1;
    in_data  = beat;
    #2 rst = 1'b0;
    #1;
    chk("rst_pe_mode", pe_mode, 2'd3);
    chk("rst_pe_in", pe_in, 8'd0);
    chk("rst_pe_filter", pe_filter, 8'd0);
    chk("rst_flags", {pe_activate, busy, done, err, flt_ready, in_ready}, 6'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    m_in = '0;
    m_filt = '0;
    q.delete();
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("no_done_after_rst", saw_done, 1'b0);
  endtask

  // Starts at a negedge in IDLE; returns at the negedge of the done cycle (or after an abort).
  task automatic run_job(input job_t j, input int abort_beat, input bit hold);
    int fi = 0, ni = 0, lc = 0, mc = 0, tap = 0, last = -1, cyc;
    bit fin = 1'b0;
    exp_t e;
    start = 1'b1;
    k_len = j.k[2:0];
    n_len = j.n[7:0];
    @(negedge clk);
    if (!hold) start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 100) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pe_mode", pe_mode, e.mode);
        chk("pe_in", pe_in, e.pin);
        chk("pe_filter", pe_filter, e.pflt);
      end else if (last < 0 || cyc < last + DRAIN + 2) begin
        chk("hold_mode", pe_mode, 2'd3);
      end
      if (last >= 0 && cyc == last + DRAIN + 2) begin
        chk("done_pulse", {done, busy, pe_activate}, 3'b100);
        chk("done_cycle", cyc, j.exp_done);
        fin = 1'b1;
      end else begin
        chk("busy_act", {busy, pe_activate, done, err}, {1'b1, (cyc >= 2), 2'b00});
      end
      flt_valid = 1'b0;
      in_valid  = 1'b0;
      if (!fin) begin
        if (flt_ready) begin
          lc++;
          if (j.fstall[lc]) begin
            q.push_back(mk(2'd3, m_in, m_filt));
          end else begin
            flt_valid = 1'b1;
            flt_data  = j.f[fi*8 +: 8];
            m_filt    = flt_data;
            mbuf[fi & 7] = flt_data;
            q.push_back(mk(2'd2, m_in, m_filt));
            fi++;
          end
        end else if (in_ready) begin
          mc++;
          if (j.mstall[mc]) begin
            q.push_back(mk(2'd3, m_in, m_filt));
          end else if (abort_beat > 0 && ni == abort_beat - 1) begin
            abort_now(j.d[ni*8 +: 8]);
            return;
          end else begin
            in_valid = 1'b1;
            in_data  = j.d[ni*8 +: 8];
            m_in     = in_data;
            m_filt   = mbuf[tap & 7];
            q.push_back(mk(2'd1, m_in, m_filt));
            ni++;
            tap = (tap == j.k - 1) ? 0 : tap + 1;
            if (ni == j.n) last = cyc;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("job_timeout", 1'b0, 1'b1);
    q.delete();
  endtask

  job_t jobs[4];
  rej_t rejs[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{3, 3, 0, 0,  32'h0004_0302, 64'h0000_0000_0003_0201, 13};
    jobs[1] = '{2, 5, 0, 0,  32'h0000_0705, 64'h0000_0005_0403_0201, 14};
    jobs[2] = '{2, 5, 0, 20, 32'h0000_0705, 64'h0000_0005_0403_0201, 16};
    jobs[3] = '{4, 2, 4, 0,  32'h0607_0809, 64'h0000_0000_0000_140a, 14};
    rejs[0] = '{0, 3, 1'b1};
    rejs[1] = '{5, 3, 1'b1};
    rejs[2] = '{3, 0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_pe_mode", pe_mode, 2'd3);
    chk("reset_pe_data", {pe_in, pe_filter}, 16'h0);
    chk("reset_flags", {pe_activate, busy, done, err, flt_ready, in_ready}, 6'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      k_len = rejs[i].k[2:0];
      n_len = rejs[i].n[7:0];
      @(negedge clk);
      start = 1'b0;
      chk("rej_err", err, rejs[i].exp_err);
      chk("rej_busy_mode", {busy, pe_activate, pe_mode}, 4'b0011);
      @(negedge clk);
      chk("rej_err_single", {err, busy, pe_mode}, 4'b0011);
    end

    for (int i = 0; i < 4; i++) begin
      run_job(jobs[i], 0, 1'b0);
      @(negedge clk);
    end

    // Reset on the 2nd MAC beat, then a clean job.
    run_job(jobs[1], 2, 1'b0);
    run_job(jobs[0], 0, 1'b0);
    @(negedge clk);

    // start held high through a whole job: next ARM immediately after the done cycle.
    run_job(jobs[0], 0, 1'b1);
    @(negedge clk);
    chk("restart_after_done", {busy, pe_mode, done}, 4'b1110);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_in = '0;
    m_filt = '0;
    @(negedge clk);
    chk("idle_after_rst", {busy, pe_activate}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
